// File: rtl/sram_port_arbiter_if.sv
// Purpose: bundles the I-port, D-port and SRAM-side signals of the shared SRAM arbiter.
// Latency: none (wiring only).
// Backpressure: req is held until ack; no backpressure exists on read data.
// Modports: slave = arbiter side (takes requests, drives the SRAM); master = core/SRAM side.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port (read only)
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    // Data port (load/store)
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // Single-port synchronous SRAM
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: shares one single-port SRAM between the I (fetch) port and the D (load/store) port.
// Latency: issue in the request cycle when the port wins; read data one cycle after issue.
// Backpressure: a losing port holds req until ack; at most one access is issued per cycle.
// Ports: clk, reset (async, active-high), bus (sram_port_arbiter_if.slave: I/D request ports + SRAM side).
// Config macro SRAM_ARB_ROUND_ROBIN_EN: when defined, conflicts alternate via rr_ptr; otherwise D has
// fixed priority and I is forced through after MAX_WAIT lost cycles.
module sram_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_t;

    rsp_t rsp;
    logic i_win;
    logic d_win;
    logic conflict;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 0 = I goes first on a conflict, 1 = D goes first
    logic rr_ptr;
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_cnt;
`endif

    always_comb begin
        conflict = bus.i_req && bus.d_req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        i_win = bus.i_req && (!bus.d_req || !rr_ptr) && !reset;
`else
        i_win = bus.i_req && (!bus.d_req || (wait_cnt == MAX_WAIT_C)) && !reset;
`endif
        // D only wins when I did not; this also guarantees no ack without req
        d_win = bus.d_req && !i_win && !reset;
    end

    assign bus.i_ack      = i_win;
    assign bus.d_ack      = d_win;
    assign bus.sram_en    = i_win || d_win;
    assign bus.sram_we    = d_win && bus.d_we;
    assign bus.sram_addr  = i_win ? bus.i_addr : (d_win ? bus.d_addr : '0);
    assign bus.sram_wdata = (d_win && bus.d_we) ? bus.d_wdata : '0;

    // Read data is steered to the port that issued the read last cycle
    assign bus.i_rvalid = (rsp == RSP_I);
    assign bus.d_rvalid = (rsp == RSP_D);
    assign bus.i_rdata  = (rsp == RSP_I) ? bus.sram_rdata : '0;
    assign bus.d_rdata  = (rsp == RSP_D) ? bus.sram_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp <= RSP_NONE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_ptr <= 1'b0;
`else
            wait_cnt <= 4'd0;
`endif
        end else begin
            if (i_win)
                rsp <= RSP_I;
            else if (d_win && !bus.d_we)
                rsp <= RSP_D;
            else
                rsp <= RSP_NONE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            // Point at the loser: I won -> D next, D won -> I next
            if (conflict)
                rr_ptr <= i_win;
`else
            if (!bus.i_req || i_win)
                wait_cnt <= 4'd0;
            else if (wait_cnt != MAX_WAIT_C)
                wait_cnt <= wait_cnt + 4'd1;
`endif
        end
    end

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    // conflict only steers the round-robin pointer
    logic unused_conflict;
    assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose: directed self-checking bench for sram_port_arbiter.
// Latency: checks issue in the request cycle and read data one cycle later.
// Backpressure: bench holds req until ack, as the core does.
module tb_sram_port_arbiter;

    localparam logic [31:0] XOR_K = 32'h1e800404;  // SRAM model: rdata = addr ^ XOR_K

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous read SRAM: data for a read issued this cycle appears next cycle
    always @(posedge clk) begin
        if (bus.sram_en && !bus.sram_we)
            bus.sram_rdata <= bus.sram_addr ^ XOR_K;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_i_ack"},      64'(bus.i_ack),      64'd0);
        chk({tag, "_d_ack"},      64'(bus.d_ack),      64'd0);
        chk({tag, "_i_rvalid"},   64'(bus.i_rvalid),   64'd0);
        chk({tag, "_d_rvalid"},   64'(bus.d_rvalid),   64'd0);
        chk({tag, "_i_rdata"},    64'(bus.i_rdata),    64'd0);
        chk({tag, "_d_rdata"},    64'(bus.d_rdata),    64'd0);
        chk({tag, "_sram_en"},    64'(bus.sram_en),    64'd0);
        chk({tag, "_sram_we"},    64'(bus.sram_we),    64'd0);
        chk({tag, "_sram_addr"},  64'(bus.sram_addr),  64'd0);
        chk({tag, "_sram_wdata"}, 64'(bus.sram_wdata), 64'd0);
    endtask

    initial begin
        bus.i_req = 1'b1; bus.i_addr = 32'h1c000000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1c000100; bus.d_wdata = 32'h0;
        reset = 1'b1;

        // Reset state: requests present but nothing may be acked or issued
        repeat (2) @(posedge clk);
        @(negedge clk);
        all_zero("reset");

        // ---- 1. Fetch only ----
        next_cycle();
        reset = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        chk("t1_i_ack",     64'(bus.i_ack),     64'd1);
        chk("t1_d_ack",     64'(bus.d_ack),     64'd0);
        chk("t1_sram_en",   64'(bus.sram_en),   64'd1);
        chk("t1_sram_we",   64'(bus.sram_we),   64'd0);
        chk("t1_sram_addr", 64'(bus.sram_addr), 64'h1c000000);
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("t1_i_rvalid",  64'(bus.i_rvalid),  64'd1);
        chk("t1_i_rdata",   64'(bus.i_rdata),   64'h02800404);
        chk("t1_d_rvalid",  64'(bus.d_rvalid),  64'd0);
        chk("t1_idle_en",   64'(bus.sram_en),   64'd0);
        chk("t1_idle_addr", 64'(bus.sram_addr), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("t1_rvalid_drop", 64'(bus.i_rvalid), 64'd0);

`ifndef SRAM_ARB_ROUND_ROBIN_EN
        // ---- 2. Conflict, fixed priority ----
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 32'h1c000040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1c000100;
        @(negedge clk);
        chk("t2_c0_d_ack",  64'(bus.d_ack),     64'd1);
        chk("t2_c0_i_ack",  64'(bus.i_ack),     64'd0);
        chk("t2_c0_addr",   64'(bus.sram_addr), 64'h1c000100);
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("t2_c1_i_ack",    64'(bus.i_ack),     64'd1);
        chk("t2_c1_d_rvalid", 64'(bus.d_rvalid),  64'd1);
        chk("t2_c1_d_rdata",  64'(bus.d_rdata),   64'h02800504);
        chk("t2_c1_i_rvalid", 64'(bus.i_rvalid),  64'd0);
        chk("t2_c1_addr",     64'(bus.sram_addr), 64'h1c000040);
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("t2_c2_i_rvalid", 64'(bus.i_rvalid), 64'd1);
        chk("t2_c2_i_rdata",  64'(bus.i_rdata),  64'h02800444);
        chk("t2_c2_d_rvalid", 64'(bus.d_rvalid), 64'd0);

        // ---- 3. Starvation guard, MAX_WAIT=4 ----
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 32'h1c000080;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1c000180;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("t3_c%0d_i_ack", c),    64'(bus.i_ack),    64'(c == 4));
            chk($sformatf("t3_c%0d_d_ack", c),    64'(bus.d_ack),    64'(c != 4));
            chk($sformatf("t3_c%0d_i_rvalid", c), 64'(bus.i_rvalid), 64'(c == 5));
            chk($sformatf("t3_c%0d_d_rvalid", c), 64'(bus.d_rvalid), 64'(c >= 1 && c <= 4));
            next_cycle();
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        next_cycle();
`endif

        // ---- 4. Store ----
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1c000200; bus.d_wdata = 32'hdeadbeef;
        @(negedge clk);
        chk("t4_d_ack",       64'(bus.d_ack),      64'd1);
        chk("t4_sram_en",     64'(bus.sram_en),    64'd1);
        chk("t4_sram_we",     64'(bus.sram_we),    64'd1);
        chk("t4_sram_addr",   64'(bus.sram_addr),  64'h1c000200);
        chk("t4_sram_wdata",  64'(bus.sram_wdata), 64'hdeadbeef);
        next_cycle();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        chk("t4_d_rvalid",    64'(bus.d_rvalid),   64'd0);
        chk("t4_i_rvalid",    64'(bus.i_rvalid),   64'd0);

        // ---- 5. Reset mid-read ----
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 32'h1c000300;
        @(negedge clk);
        chk("t5_c0_i_ack", 64'(bus.i_ack), 64'd1);
        next_cycle();
        reset = 1'b1;
        #1;
        all_zero("t5_in_reset");
        @(negedge clk);
        all_zero("t5_in_reset_neg");
        next_cycle();
        reset = 1'b0; bus.i_req = 1'b0;
        @(negedge clk);
        chk("t5_post_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        chk("t5_post_i_rdata",  64'(bus.i_rdata),  64'd0);
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 32'h1c000300;
        @(negedge clk);
        chk("t5_reack_i_ack", 64'(bus.i_ack),     64'd1);
        chk("t5_reack_addr",  64'(bus.sram_addr), 64'h1c000300);
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("t5_reack_rvalid", 64'(bus.i_rvalid), 64'd1);
        chk("t5_reack_rdata",  64'(bus.i_rdata),  64'h02800704);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
        // ---- 6. Round robin: I,D,I,D after reset ----
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h1c000040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1c000100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                chk($sformatf("t6_c%0d_i_ack", c), 64'(bus.i_ack), 64'(c % 2 == 0));
                chk($sformatf("t6_c%0d_d_ack", c), 64'(bus.d_ack), 64'(c % 2 == 1));
            end
            chk($sformatf("t6_c%0d_i_rvalid", c), 64'(bus.i_rvalid), 64'(c >= 1 && c % 2 == 1));
            chk($sformatf("t6_c%0d_d_rvalid", c), 64'(bus.d_rvalid), 64'(c >= 1 && c % 2 == 0));
            next_cycle();
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
`endif

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
